// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encoding and default width for the HI/LO mul/div sequencer.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Command/result bundle between the control unit (master) and the HI/LO sequencer (slave).
interface hilo_muldiv_ctrl_if #(parameter int WIDTH = muldiv_pkg::DEF_WIDTH);
  logic             start;
  logic [1:0]       op;
  logic             sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] outHI;
  logic [WIDTH-1:0] outLO;

  modport master (output start, op, sign, A, B, input busy, done, outHI, outLO);
  modport slave  (input start, op, sign, A, B, output busy, done, outHI, outLO);
endinterface

// File: rtl/hilo_muldiv_ctrl_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] val,
  output logic [W-1:0] res
);
  assign res = en ? -val : val;
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative shift-add multiply / restoring divide owning the HI/LO pair.
// Optional MULDIV_DIVZERO_FLAG_EN: early-out divide by zero with a div_zero pulse.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  hilo_muldiv_ctrl_if.slave bus
`ifdef MULDIV_DIVZERO_FLAG_EN
  , output logic div_zero
`endif
);
  state_e           state, state_nxt;
  op_e              op;
  logic             accept, mdiv_go;
  logic [WIDTH-1:0] a_mag, b_mag, mb, acc_hi, acc_lo, out_hi, out_lo;
  logic [WIDTH-1:0] rem_fix, quo_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r, done;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ok;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic             dz_go, dz_pend;
  assign dz_go = accept && op == OP_DIV && bus.B == '0;
`endif

  assign op      = op_e'(bus.op);
  assign accept  = bus.start && state == ST_IDLE;
  assign mdiv_go = accept && (op == OP_MULT || op == OP_DIV);

  muldiv_negate #(.W(WIDTH))   u_abs_a (.en(bus.sign & bus.A[WIDTH-1]), .val(bus.A), .res(a_mag));
  muldiv_negate #(.W(WIDTH))   u_abs_b (.en(bus.sign & bus.B[WIDTH-1]), .val(bus.B), .res(b_mag));
  muldiv_negate #(.W(2*WIDTH)) u_fix_p (.en(neg_q), .val({acc_hi, acc_lo}), .res(prod_fix));
  muldiv_negate #(.W(WIDTH))   u_fix_q (.en(neg_q), .val(acc_lo), .res(quo_fix));
  muldiv_negate #(.W(WIDTH))   u_fix_r (.en(neg_r), .val(acc_hi), .res(rem_fix));

  // acc_lo holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first)
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, mb};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mdiv_go) state_nxt = ST_CALC;
`ifdef MULDIV_DIVZERO_FLAG_EN
        if (dz_go) state_nxt = ST_FIX;
`endif
      end
      ST_CALC: if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_hi <= '0;
      out_lo <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mb     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_pend  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
      if (accept && op == OP_MTHI) out_hi <= bus.A;
      if (accept && op == OP_MTLO) out_lo <= bus.A;
      if (mdiv_go) begin
        mb     <= b_mag;
        acc_hi <= '0;
        acc_lo <= a_mag;
        cnt    <= CNT_W'(WIDTH);
        is_div <= op == OP_DIV;
        neg_q  <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        neg_r  <= bus.sign & bus.A[WIDTH-1];
`ifdef MULDIV_DIVZERO_FLAG_EN
        dz_pend <= dz_go;
        // Divide by zero commits the raw dividend, bypassing sign fix-up
        if (dz_go) begin
          acc_hi <= bus.A;
          acc_lo <= '1;
          neg_q  <= 1'b0;
          neg_r  <= 1'b0;
        end
`endif
      end
      if (state == ST_CALC) begin
        cnt <= cnt - CNT_W'(1);
        if (is_div) begin
          acc_hi <= WIDTH'(div_ok ? (div_shift - {1'b0, mb}) : div_shift);
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
        end else begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end
      end
      if (state == ST_FIX) begin
        if (is_div) begin
          out_hi <= rem_fix;
          out_lo <= quo_fix;
        end else begin
          {out_hi, out_lo} <= prod_fix;
        end
        done <= 1'b1;
`ifdef MULDIV_DIVZERO_FLAG_EN
        div_zero <= dz_pend;
`endif
      end
    end
  end

  assign bus.busy  = state != ST_IDLE;
  assign bus.done  = done;
  assign bus.outHI = out_hi;
  assign bus.outLO = out_lo;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed mul/div vectors, MTHI/MTLO, busy-ignore and reset abort.
module tb_hilo_muldiv_ctrl;
  import muldiv_pkg::*;
  localparam int W = 32;
`ifdef MULDIV_DIVZERO_FLAG_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic div_zero;
`endif

  hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MULDIV_DIVZERO_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
    int           lat;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on done, and checks HI/LO hold steady while busy.
  logic [W-1:0] prev_hi, prev_lo;
  logic         prev_busy = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_hi", bus.outHI, e.hi);
          chk("result_lo", bus.outLO, e.lo);
          chk("latency_edges", cyc - e.acc, e.lat);
          chk("busy_with_done", bus.busy, 0);
`ifdef MULDIV_DIVZERO_FLAG_EN
          chk("div_zero", div_zero, e.dz);
`endif
        end
      end else if (prev_busy) begin
        chk("hold_hi", bus.outHI, prev_hi);
        chk("hold_lo", bus.outLO, prev_lo);
      end
    end
    prev_hi   = bus.outHI;
    prev_lo   = bus.outLO;
    prev_busy = bus.busy && !reset;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
  endtask

  // Latency in edges from the accept edge: WIDTH+1 edges = WIDTH+2 cycles counting the accept cycle.
  task automatic issue(input logic [1:0] op, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input int lat, input logic dz);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.sign  = sg;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    e.hi = eh; e.lo = el; e.acc = cyc; e.lat = lat; e.dz = dz;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    // Reset with a command pending: reset must win.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.sign = 1'b0;
    bus.A = 32'd9;
    bus.B = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_hi", bus.outHI, 0);
    chk("reset_lo", bus.outLO, 0);
    @(negedge clk);
    chk("reset_start_dropped", bus.busy, 0);

    issue(OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, W + 1, 1'b0);
    issue(OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, W + 1, 1'b0);
    issue(OP_DIV,  1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, W + 1, 1'b0);
    issue(OP_DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, W + 1, 1'b0);
    issue(OP_MULT, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, W + 1, 1'b0);
    wait_drain();

    // MTHI then MTLO on consecutive edges
    wait_idle();
    bus.start = 1'b1;
    bus.op = OP_MTHI;
    bus.A = 32'h12345678;
    @(posedge clk);
    #1;
    chk("mthi_hi", bus.outHI, 32'h12345678);
    chk("mthi_busy", bus.busy, 0);
    @(negedge clk);
    bus.op = OP_MTLO;
    bus.A = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    chk("mtlo_lo", bus.outLO, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", bus.outHI, 32'h12345678);
    chk("mtlo_busy", bus.busy, 0);
    chk("mtlo_done", bus.done, 0);
    @(negedge clk);
    bus.start = 1'b0;

    // DIV 100/7 with a MULT start ignored while busy
    issue(OP_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, W + 1, 1'b0);
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.A = 32'd3;
    bus.B = 32'd3;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    issue(OP_DIV, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DZ_LAT, 1'b1);
    wait_drain();

    // Reset during the 10th CALC cycle aborts the op
    wait_idle();
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.sign = 1'b0;
    bus.A = 32'h1234;
    bus.B = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.outHI, 0);
    chk("abort_lo", bus.outLO, 0);
    issue(OP_MULT, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, W + 1, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
